// File: rtl/ram_march_bist.sv
// March-style RAM self test: W0 ascending, R0 ascending, W1 descending, R1 descending.
// Reads are pipelined one cycle; each compare checks the read issued in the previous cycle.
module ram_march_bist #(
  parameter logic [7:0] PATTERN = 8'h55,
  parameter int         DEPTH   = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data_out,
  output logic [5:0] ram_address,
  output logic [7:0] data_in,
  output logic       write_enable,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [5:0] error_count,
  output logic [5:0] fail_addr,
  output logic [7:0] fail_data
);

  localparam logic [4:0] LAST = 5'(DEPTH - 1);

  typedef enum logic [2:0] {IDLE, W0, R0, R0D, W1, R1, R1D, DONE} state_t;

  state_t     state_q;
  logic [4:0] addr_q;
  logic       we_q;
  logic [7:0] wdata_q;
  logic       busy_q, done_q, pass_q;
  logic [5:0] err_q, err_d;
  logic [5:0] fail_addr_q;
  logic [7:0] fail_data_q;
  logic       chk_q;
  logic [4:0] chk_addr_q;
  logic [7:0] chk_exp_q;
  logic       mismatch;

  always_comb begin
    mismatch = chk_q && (data_out != chk_exp_q);
    err_d    = err_q;
    if (mismatch && (err_q != 6'd63)) err_d = err_q + 6'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_q       <= '0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
      chk_q       <= 1'b0;
      chk_addr_q  <= '0;
      chk_exp_q   <= '0;
    end else begin
      chk_q <= 1'b0;
      // Compare of the previous cycle's read; start acceptance below overrides the clear
      if (mismatch) begin
        err_q <= err_d;
        if (err_q == 6'd0) begin
          fail_addr_q <= {1'b0, chk_addr_q};
          fail_data_q <= data_out;
        end
      end
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q     <= W0;
            addr_q      <= '0;
            we_q        <= 1'b1;
            wdata_q     <= PATTERN;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_q       <= '0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
          end
        end
        W0: begin
          if (addr_q == LAST) begin
            state_q <= R0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
          end else begin
            addr_q <= addr_q + 5'd1;
          end
        end
        R0: begin
          chk_q      <= 1'b1;
          chk_addr_q <= addr_q;
          chk_exp_q  <= PATTERN;
          if (addr_q == LAST) state_q <= R0D;
          else                addr_q  <= addr_q + 5'd1;
        end
        R0D: begin
          state_q <= W1;
          addr_q  <= LAST;
          we_q    <= 1'b1;
          wdata_q <= ~PATTERN;
        end
        W1: begin
          if (addr_q == 5'd0) begin
            state_q <= R1;
            addr_q  <= LAST;
            we_q    <= 1'b0;
            wdata_q <= '0;
          end else begin
            addr_q <= addr_q - 5'd1;
          end
        end
        R1: begin
          chk_q      <= 1'b1;
          chk_addr_q <= addr_q;
          chk_exp_q  <= ~PATTERN;
          if (addr_q == 5'd0) state_q <= R1D;
          else                addr_q  <= addr_q - 5'd1;
        end
        R1D: begin
          state_q <= DONE;
          addr_q  <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          pass_q  <= (err_d == 6'd0);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ram_address  = {1'b0, addr_q};
  assign data_in      = wdata_q;
  assign write_enable = we_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign error_count  = err_q;
  assign fail_addr    = fail_addr_q;
  assign fail_data    = fail_data_q;

endmodule

// File: tb/tb_ram_march_bist.sv
// Directed bench for ram_march_bist with a registered-read RAM model and selectable faults.
module tb_ram_march_bist;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] data_out;
  logic [5:0] ram_address;
  logic [7:0] data_in;
  logic       write_enable;
  logic       busy, done, pass;
  logic [5:0] error_count, fail_addr;
  logic [7:0] fail_data;

  int tests  = 0;
  int failed = 0;
  int fault  = 0;     // 0 none, 1 addr5 bit3 stuck-at-0, 2 reads return 0
  int wr_n   = 0;
  int wr_bad = 0;

  logic [7:0] mem [0:31];
  logic [7:0] rd_v;

  ram_march_bist dut (
    .clk(clk), .rst_n(rst_n), .start(start), .data_out(data_out),
    .ram_address(ram_address), .data_in(data_in), .write_enable(write_enable),
    .busy(busy), .done(done), .pass(pass), .error_count(error_count),
    .fail_addr(fail_addr), .fail_data(fail_data)
  );

  always #5 clk = ~clk;

  // RAM under test: address registered, read data valid the following cycle
  always @(posedge clk) begin
    if (write_enable) begin
      mem[ram_address[4:0]] <= data_in;
    end else begin
      rd_v = mem[ram_address[4:0]];
      if (fault == 1 && ram_address == 6'd5) rd_v[3] = 1'b0;
      if (fault == 2) rd_v = 8'h00;
      data_out <= rd_v;
    end
  end

  // Write-order monitor: expects 0..31 with 0x55, then 31..0 with 0xAA
  always @(posedge clk) begin
    if (start && !busy) begin
      wr_n   = 0;
      wr_bad = 0;
    end else if (write_enable) begin
      if (wr_n < 32) begin
        if (ram_address != 6'(wr_n) || data_in != 8'h55) wr_bad++;
      end else begin
        if (ram_address != 6'(63 - wr_n) || data_in != 8'hAA) wr_bad++;
      end
      wr_n++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run(input string name, input int flt, input bit mid_start,
                     input int exp_err, input int exp_fa, input int exp_fd);
    int n = 0;
    int busy_cnt = 0;
    fault = flt;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check({name, "_accept_busy"}, busy, 1);
    check({name, "_accept_done"}, done, 0);
    check({name, "_accept_pass"}, pass, 0);
    while (!done && n < 400) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      n++;
      start = (mid_start && n == 40);
    end
    start = 1'b0;
    check({name, "_cycles"}, n, 130);
    check({name, "_busy_cycles"}, busy_cnt, 130);
    check({name, "_pass"}, pass, (exp_err == 0) ? 1 : 0);
    check({name, "_errs"}, error_count, exp_err);
    check({name, "_fail_addr"}, fail_addr, exp_fa);
    check({name, "_fail_data"}, fail_data, exp_fd);
    check({name, "_done_busy"}, busy, 0);
    check({name, "_done_we"}, write_enable, 0);
    check({name, "_done_addr"}, ram_address, 0);
    $display("[TB] run %s: cycles=%0d pass=%0d errors=%0d fail_addr=%0d fail_data=%02h",
             name, n, pass, error_count, fail_addr, fail_data);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_errs", error_count, 0);
    check("rst_we", write_enable, 0);
    check("rst_addr", ram_address, 0);
    check("rst_din", data_in, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", busy, 0);

    run("clean", 0, 1'b0, 0, 0, 0);
    check("clean_wr_count", wr_n, 64);
    check("clean_wr_order", wr_bad, 0);
    repeat (5) @(negedge clk);
    check("hold_done", done, 1);
    check("hold_pass", pass, 1);

    run("rerun", 0, 1'b0, 0, 0, 0);
    check("rerun_wr_count", wr_n, 64);
    check("rerun_wr_order", wr_bad, 0);

    run("stuck_bit", 1, 1'b0, 1, 5, 8'hA2);
    run("all_zero", 2, 1'b0, 63, 0, 8'h00);
    run("mid_start", 0, 1'b1, 0, 0, 0);

    // Reset in the middle of W1 with errors already accumulated
    fault = 2;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (70) @(negedge clk);
    check("pre_rst_we", write_enable, 1);
    check("pre_rst_errs", error_count, 32);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_we", write_enable, 0);
    check("arst_addr", ram_address, 0);
    check("arst_din", data_in, 0);
    check("arst_errs", error_count, 0);
    check("arst_fail_data", fail_data, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_idle", busy, 0);
    check("post_rst_done", done, 0);
    run("after_reset", 0, 1'b0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/ram_march_bist.md
RAM_MARCH_BIST -- requirements
Module: ram_march_bist

Interface
REQ-001 Parameter PATTERN, default 8'h55, background data written in phase W0; phase W1 writes ~PATTERN.
REQ-002 Parameter DEPTH, default 32, number of RAM words tested (addresses 0..DEPTH-1).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request to run one test; sampled only in IDLE.
REQ-006 data_out  input  8  read data from the RAM under test.
REQ-007 ram_address  output  6  RAM address; bit 5 is always 0.
REQ-008 data_in  output  8  RAM write data.
REQ-009 write_enable  output  1  RAM write strobe; 0 means read (RAM registers the address).
REQ-010 busy  output  1  test in progress.
REQ-011 done  output  1  test complete; held until the next accepted start.
REQ-012 pass  output  1  valid while done=1; 1 when error_count=0.
REQ-013 error_count  output  6  mismatch count, saturating at 63.
REQ-014 fail_addr  output  6  address of the first mismatch.
REQ-015 fail_data  output  8  data_out captured at the first mismatch.

Function
REQ-016 RAM read timing: address driven with write_enable=0 in cycle N; data_out valid in cycle N+1; block SHALL sample it at the end of N+1.
REQ-017 FSM states SHALL be IDLE, W0, R0, R0D, W1, R1, R1D, DONE.
REQ-018 IDLE or DONE with start=1 at an edge -> W0; counters, fail_addr, fail_data and error_count cleared at that edge; done and pass go low.
REQ-019 W0: write_enable=1, data_in=PATTERN, ascending address 0..DEPTH-1, one word per cycle; DEPTH cycles, then -> R0.
REQ-020 R0: write_enable=0, ascending address 0..DEPTH-1, one read per cycle (pipelined); DEPTH cycles, then -> R0D.
REQ-021 R0D: single drain cycle; address holds DEPTH-1, write_enable=0; compares the last R0 read; -> W1.
REQ-022 W1: write_enable=1, data_in=~PATTERN, descending address DEPTH-1..0; DEPTH cycles, then -> R1.
REQ-023 R1: descending reads DEPTH-1..0 with expected ~PATTERN; DEPTH cycles, then -> R1D (drain, address holds 0) -> DONE.
REQ-024 Compare: in each cycle after a read issue, data_out != expected SHALL increment error_count (saturating at 63); on the first mismatch of a run, the issued address and data_out are latched into fail_addr and fail_data.
REQ-025 Mismatches SHALL NOT stop the run; all phases always complete.
REQ-026 busy SHALL be 1 in W0..R1D; run length from start acceptance to DONE entry is exactly 4*DEPTH+2 cycles (130 at default).
REQ-027 DONE: done=1, busy=0, pass=(error_count==0); outputs held.
REQ-028 start while busy=1 SHALL be ignored, with no effect on state or outputs.
REQ-029 In IDLE and DONE: write_enable=0, ram_address=0, data_in=0.
REQ-030 write_enable SHALL be 1 only in W0 and W1.

Reset
REQ-031 rst_n low SHALL immediately force IDLE, busy=0, done=0, pass=0, error_count=0, fail_addr=0, fail_data=0, write_enable=0, ram_address=0, data_in=0.
REQ-032 Reset asserted mid-run SHALL abort the run; after release, the block waits in IDLE for a new start.

Verification
REQ-033 Fault-free RAM model, start pulse -> busy for 130 cycles, then done=1, pass=1, error_count=0; write sequence 0..31 with 0x55, then 31..0 with 0xAA.
REQ-034 RAM model with bit 3 of address 5 stuck at 0 -> done with pass=0, error_count=1, fail_addr=5, fail_data=0xA2.
REQ-035 RAM model returning 0x00 for every read -> error_count saturates at 63; fail_addr=0, fail_data=0x00 from the first R0 read.
REQ-036 start pulsed at cycle 40 of a run -> no restart; done still arrives 130 cycles after the original start.
REQ-037 rst_n pulsed low at cycle 70 -> all outputs return to reset values asynchronously; a new start then produces a full 130-cycle run with pass=1.
REQ-038 Second start while done=1 -> done and pass drop at the accepting edge; the second run repeats REQ-033 results.
